// File: rtl/frame_buffer_if.sv
// Write-side bus of the frame buffer: GPU (master) pushes pixels with a
// valid/ready handshake; the frame buffer (slave) accepts them.
interface frame_buffer_if #(
    parameter int FB_WIDTH  = 80,
    parameter int FB_HEIGHT = 60
);
    localparam int X_W = $clog2(FB_WIDTH);
    localparam int Y_W = $clog2(FB_HEIGHT);

    logic           wr_valid_in;
    logic           wr_ready_out;
    logic [X_W-1:0] wr_x_in;
    logic [Y_W-1:0] wr_y_in;
    logic [3:0]     wr_data_in;

    modport master (
        output wr_valid_in, wr_x_in, wr_y_in, wr_data_in,
        input  wr_ready_out
    );

    modport slave (
        input  wr_valid_in, wr_x_in, wr_y_in, wr_data_in,
        output wr_ready_out
    );
endinterface

// File: rtl/frame_buffer.sv
// 4-bit gray-scale frame buffer feeding the VGA driver.
// Sequential read pointer driven by next_pixel / h_sync rising edges with
// vertical line repetition; random-access write port from the GPU.
// Optional macro FB_DOUBLE_BUFFER_EN: two banks, front/back swap on the
// rising edge of frame_reset_in after a swap request.
module frame_buffer #(
    parameter int FB_WIDTH     = 80,
    parameter int FB_HEIGHT    = 60,
    parameter int WIDTH_REPEAT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_REPEAT-1:0] line_repeat_in,
    input  logic                    frame_next_pixel_in,
    input  logic                    frame_reset_in,
    input  logic                    h_sync_in,
    output logic [3:0]              frame_pixel_out,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic                    swap_req_in,
    output logic                    swap_pending_out,
`endif
    frame_buffer_if.slave           wr
);
    localparam int X_W    = $clog2(FB_WIDTH);
    localparam int Y_W    = $clog2(FB_HEIGHT);
    localparam int ADDR_W = $clog2(FB_WIDTH*FB_HEIGHT);
    localparam int DEPTH  = FB_WIDTH*FB_HEIGHT;

    logic                    r_next_prev;
    logic                    r_hs_prev;
    logic [X_W-1:0]          r_rd_x;
    logic [Y_W-1:0]          r_rd_y;
    logic [ADDR_W-1:0]       r_row_base;
    logic [WIDTH_REPEAT-1:0] r_rep_ctr;
    logic [WIDTH_REPEAT-1:0] r_rep_cfg;
    logic [3:0]              r_pix;
    logic                    r_wr_ready;

    logic                    w_nx_edge;
    logic                    w_hs_edge;
    logic [ADDR_W-1:0]       w_rd_addr;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic                    w_wr_in_range;
    logic                    w_wr_fire;
    logic                    w_pending_next;

    assign w_nx_edge = frame_next_pixel_in & ~r_next_prev;
    assign w_hs_edge = h_sync_in & ~r_hs_prev;

    // Row base is accumulated, so the read path needs only an adder.
    assign w_rd_addr = r_row_base + ADDR_W'(r_rd_x);

    // Write address uses a constant multiply; out-of-range writes are
    // still handshaken but never reach the array.
    assign w_wr_addr     = ADDR_W'(int'(wr.wr_y_in) * FB_WIDTH + int'(wr.wr_x_in));
    assign w_wr_in_range = (int'(wr.wr_x_in) < FB_WIDTH) && (int'(wr.wr_y_in) < FB_HEIGHT);
    assign w_wr_fire     = rst_n & wr.wr_valid_in & r_wr_ready & w_wr_in_range;

    assign frame_pixel_out = r_pix;
    assign wr.wr_ready_out = r_wr_ready;

    // Edge-detect history of the VGA strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_next_prev <= 1'b0;
            r_hs_prev   <= 1'b0;
        end else begin
            r_next_prev <= frame_next_pixel_in;
            r_hs_prev   <= h_sync_in;
        end
    end

    // Read pointer: frame reset > line end > next pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_row_base <= '0;
            r_rep_ctr  <= '0;
            r_rep_cfg  <= '0;
        end else if (frame_reset_in) begin
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_row_base <= '0;
            r_rep_ctr  <= '0;
            r_rep_cfg  <= line_repeat_in;
        end else if (w_hs_edge) begin
            r_rd_x <= '0;
            if (r_rep_ctr == r_rep_cfg) begin
                r_rep_ctr <= '0;
                // Rows past the last one keep showing the last row.
                if (r_rd_y != Y_W'(FB_HEIGHT-1)) begin
                    r_rd_y     <= r_rd_y + 1'b1;
                    r_row_base <= r_row_base + ADDR_W'(FB_WIDTH);
                end
            end else begin
                r_rep_ctr <= r_rep_ctr + 1'b1;
            end
        end else if (w_nx_edge && (r_rd_x != X_W'(FB_WIDTH-1))) begin
            r_rd_x <= r_rd_x + 1'b1;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic [3:0] r_mem [2][DEPTH];
    logic       r_front_sel;
    logic       r_swap_pending;
    logic       r_fr_prev;
    logic       w_fr_rise;
    logic       w_do_swap;

    assign w_fr_rise        = frame_reset_in & ~r_fr_prev;
    assign w_do_swap        = w_fr_rise & (r_swap_pending | swap_req_in);
    assign w_pending_next   = ~w_do_swap & (r_swap_pending | swap_req_in);
    assign swap_pending_out = r_swap_pending;

    // Swap request is held until the next frame start, then banks flip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_fr_prev      <= 1'b0;
        end else begin
            r_fr_prev      <= frame_reset_in;
            r_swap_pending <= w_pending_next;
            if (w_do_swap)
                r_front_sel <= ~r_front_sel;
        end
    end

    // Writes land in the back bank only.
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[~r_front_sel][w_wr_addr] <= wr.wr_data_in;
    end

    // Registered read of the front bank; old data wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pix <= '0;
        else
            r_pix <= r_mem[r_front_sel][w_rd_addr];
    end
`else
    logic [3:0] r_mem [DEPTH];

    assign w_pending_next = 1'b0;

    // Single-bank write.
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[w_wr_addr] <= wr.wr_data_in;
    end

    // Registered read; old data wins on a collision.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pix <= '0;
        else
            r_pix <= r_mem[w_rd_addr];
    end
`endif

    // Write acceptance: stalls only while a bank swap is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wr_ready <= 1'b1;
        else
            r_wr_ready <= ~w_pending_next;
    end
endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: directed stimulus, a position/queue-free model of
// the display scan (line and pixel counts since frame start), per-cycle
// comparison, plus literal spot values.
module tb_frame_buffer;
    localparam int W   = 80;
    localparam int H   = 60;
    localparam int X_W = $clog2(W);
    localparam int Y_W = $clog2(H);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] line_repeat = '0;
    logic       next_px = 1'b0;
    logic       frame_reset = 1'b1;
    logic       h_sync = 1'b0;
    logic [3:0] pix_out;
`ifdef FB_DOUBLE_BUFFER_EN
    logic       swap_req = 1'b0;
    logic       swap_pending;
`endif

    always #5 clk = ~clk;

    frame_buffer_if #(.FB_WIDTH(W), .FB_HEIGHT(H)) wr_if ();

    frame_buffer #(.FB_WIDTH(W), .FB_HEIGHT(H), .WIDTH_REPEAT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .line_repeat_in      (line_repeat),
        .frame_next_pixel_in (next_px),
        .frame_reset_in      (frame_reset),
        .h_sync_in           (h_sync),
        .frame_pixel_out     (pix_out),
`ifdef FB_DOUBLE_BUFFER_EN
        .swap_req_in         (swap_req),
        .swap_pending_out    (swap_pending),
`endif
        .wr                  (wr_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit armed  = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [3:0] pat(int x, int y);
        return 4'((x*7 + y*3 + 1) & 15);
    endfunction

    // ---------------- model ----------------
    logic [3:0] m_mem [2][W*H];
    int         m_lines = 0;
    int         m_pix   = 0;
    int         m_rep   = 0;
    int         m_row, m_col;
    logic       m_nprev = 1'b0, m_hprev = 1'b0, m_fprev = 1'b0;
    logic       m_front = 1'b0, m_pend = 1'b0, m_ready = 1'b1;
    logic [3:0] m_out = '0;
    logic [3:0] m_rd;
    logic       m_sreq;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_lines = 0; m_pix = 0;
            m_nprev = 0; m_hprev = 0; m_fprev = 0;
            m_front = 0; m_pend = 0; m_ready = 1; m_out = '0;
        end else begin
            // Displayed row = lines since frame start / repeat count, clamped.
            m_row = m_lines / (m_rep + 1);
            if (m_row > H-1) m_row = H-1;
            m_col = (m_pix > W-1) ? W-1 : m_pix;
            m_rd  = m_mem[DB ? m_front : 1'b0][m_row*W + m_col];
            if (wr_if.wr_valid_in && m_ready && int'(wr_if.wr_x_in) < W && int'(wr_if.wr_y_in) < H)
                m_mem[DB ? !m_front : 1'b0][int'(wr_if.wr_y_in)*W + int'(wr_if.wr_x_in)] = wr_if.wr_data_in;
            m_out = m_rd;
            if (frame_reset) begin
                m_lines = 0; m_pix = 0; m_rep = int'(line_repeat);
            end else if (h_sync && !m_hprev) begin
                m_lines++; m_pix = 0;
            end else if (next_px && !m_nprev) begin
                m_pix++;
            end
            m_nprev = next_px;
            m_hprev = h_sync;
`ifdef FB_DOUBLE_BUFFER_EN
            m_sreq = swap_req;
`else
            m_sreq = 1'b0;
`endif
            if (frame_reset && !m_fprev && (m_pend || m_sreq)) begin
                m_front = !m_front; m_pend = 0;
            end else if (m_sreq) begin
                m_pend = 1;
            end
            m_fprev = frame_reset;
            m_ready = !m_pend;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("pixel", int'(pix_out), int'(m_out));
            chk("wr_ready", int'(wr_if.wr_ready_out), int'(m_ready));
`ifdef FB_DOUBLE_BUFFER_EN
            chk("swap_pending", int'(swap_pending), int'(m_pend));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int x, int y, logic [3:0] d);
        wr_if.wr_valid_in = 1'b1;
        wr_if.wr_x_in     = X_W'(x);
        wr_if.wr_y_in     = Y_W'(y);
        wr_if.wr_data_in  = d;
        for (int i = 0; i < 200; i++) begin
            if (wr_if.wr_ready_out) begin
                step(1);
                wr_if.wr_valid_in = 1'b0;
                return;
            end
            step(1);
        end
        wr_if.wr_valid_in = 1'b0;
        chk("write_accept_timeout", 0, 1);
    endtask

    task automatic nxt();
        next_px = 1'b1; step(1); next_px = 1'b0; step(1);
    endtask

    task automatic hs();
        h_sync = 1'b1; step(1); h_sync = 1'b0; step(1);
    endtask

    task automatic new_frame();
        frame_reset = 1'b1; step(2); frame_reset = 1'b0; step(1);
    endtask

    task automatic init_mem();
        wr_if.wr_valid_in = 1'b1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                wr_if.wr_x_in    = X_W'(x);
                wr_if.wr_y_in    = Y_W'(y);
                wr_if.wr_data_in = pat(x, y);
                step(1);
            end
        wr_if.wr_valid_in = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        wr_if.wr_valid_in = 1'b0;
        wr_if.wr_x_in     = '0;
        wr_if.wr_y_in     = '0;
        wr_if.wr_data_in  = '0;
        step(2);
        chk("reset_pixel", int'(pix_out), 0);
        chk("reset_ready", int'(wr_if.wr_ready_out), 1);
        rst_n = 1'b1;
        step(1);
        init_mem();
`ifdef FB_DOUBLE_BUFFER_EN
        // Fill both banks: swap once, fill the other one.
        frame_reset = 1'b0;
        swap_req = 1'b1; step(1); swap_req = 1'b0; step(1);
        frame_reset = 1'b1; step(2);
        init_mem();
        step(1);
        armed = 1'b1;

        // Front is bank 1, back is bank 0.
        frame_reset = 1'b0;
        wr(0, 0, 4'h7);
        step(2);
        chk("db_front_untouched", int'(pix_out), int'(pat(0, 0)));
        swap_req = 1'b1; step(1); swap_req = 1'b0;
        chk("db_pending_set", int'(swap_pending), 1);
        chk("db_ready_low", int'(wr_if.wr_ready_out), 0);
        swap_req = 1'b1; step(1); swap_req = 1'b0;
        fork
            wr(1, 0, 4'h3);
            begin
                step(3);
                chk("db_stall_ready", int'(wr_if.wr_ready_out), 0);
                frame_reset = 1'b1;
                step(1);
                chk("db_pending_clear", int'(swap_pending), 0);
                chk("db_ready_back", int'(wr_if.wr_ready_out), 1);
                step(1);
                chk("db_new_front", int'(pix_out), 7);
            end
        join
        frame_reset = 1'b0;
        step(1);
        nxt();
        chk("db_front_1_0", int'(pix_out), int'(pat(1, 0)));
        // Request coinciding with the frame start swaps at once.
        swap_req = 1'b1; frame_reset = 1'b1; step(1); swap_req = 1'b0;
        chk("db_same_cycle_swap", int'(swap_pending), 0);
        step(1);
        chk("db_back_to_bank1", int'(pix_out), int'(pat(0, 0)));
        frame_reset = 1'b0;
        step(1);
        nxt();
        chk("db_stalled_write_landed", int'(pix_out), 3);
`else
        step(1);
        armed = 1'b1;

        // Basic read.
        wr(0, 0, 4'h5);
        wr(1, 0, 4'hA);
        step(3);
        frame_reset = 1'b0;
        step(1);
        chk("basic_first", int'(pix_out), 5);
        next_px = 1'b1; step(1);
        chk("basic_latency_hold", int'(pix_out), 5);
        next_px = 1'b0; step(1);
        chk("basic_second", int'(pix_out), 10);

        // Line repeat = 1 (each row shown twice).
        frame_reset = 1'b1;
        line_repeat = 4'd1;
        for (int x = 0; x < W; x++) begin
            wr(x, 0, 4'h1);
            wr(x, 1, 4'h2);
        end
        step(2);
        frame_reset = 1'b0;
        step(1);
        chk("rep_line0", int'(pix_out), 1);
        hs(); chk("rep_line1", int'(pix_out), 1);
        hs(); chk("rep_line2", int'(pix_out), 2);
        hs(); chk("rep_line3", int'(pix_out), 2);
        hs(); chk("rep_line4", int'(pix_out), int'(pat(0, 2)));

        // Column saturation.
        line_repeat = 4'd0;
        new_frame();
        hs(); hs();
        repeat (W + 3) nxt();
        chk("col_saturate", int'(pix_out), int'(pat(79, 2)));

        // Row saturation.
        new_frame();
        repeat (70) hs();
        chk("row_saturate", int'(pix_out), int'(pat(0, 59)));
        repeat (3) nxt();
        chk("row_saturate_col3", int'(pix_out), int'(pat(3, 59)));

        // h_sync and next_pixel in the same cycle.
        new_frame();
        repeat (3) hs();
        repeat (5) nxt();
        chk("pre_collide", int'(pix_out), int'(pat(5, 3)));
        h_sync = 1'b1; next_px = 1'b1; step(1);
        h_sync = 1'b0; next_px = 1'b0; step(1);
        chk("hs_nx_same_cycle", int'(pix_out), int'(pat(0, 4)));
        nxt();
        chk("after_dropped_nx", int'(pix_out), int'(pat(1, 4)));

        // Out-of-range write: accepted, discarded (would alias to (0,1)).
        wr_if.wr_valid_in = 1'b1;
        wr_if.wr_x_in     = X_W'(80);
        wr_if.wr_y_in     = '0;
        wr_if.wr_data_in  = 4'hF;
        chk("oor_ready", int'(wr_if.wr_ready_out), 1);
        step(1);
        wr_if.wr_valid_in = 1'b0;
        frame_reset = 1'b1; step(2);
        chk("oor_cell_0_0", int'(pix_out), 1);
        frame_reset = 1'b0; step(1);
        hs();
        chk("oor_cell_0_1", int'(pix_out), 2);

        // Read/write collision at (0,1).
        wr_if.wr_valid_in = 1'b1;
        wr_if.wr_x_in     = '0;
        wr_if.wr_y_in     = Y_W'(1);
        wr_if.wr_data_in  = 4'h9;
        step(1);
        wr_if.wr_valid_in = 1'b0;
        chk("collide_old", int'(pix_out), 2);
        step(1);
        chk("collide_new", int'(pix_out), 9);

        // Reset in the middle of a frame.
        new_frame();
        repeat (10) hs();
        repeat (20) nxt();
        rst_n = 1'b0;
        step(1);
        chk("midreset_pixel", int'(pix_out), 0);
        chk("midreset_ready", int'(wr_if.wr_ready_out), 1);
        rst_n = 1'b1;
        step(1);
        chk("midreset_origin", int'(pix_out), 1);
`endif
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
